mem_seq_ctrl: RTL and testbench

MEM_SEQ_CTRL -- requirements
Module: mem_seq_ctrl

---
 rtl/mem_seq_ctrl_pkg.sv | 32 +++
 rtl/mem_seq_ctrl_load_extend.sv | 43 ++++
 rtl/mem_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_seq_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_ctrl_pkg.sv
// Shared types for the byte-serial MEM-stage sequencer.
// Holds FSM states, access-size encodings and exception causes.
package mem_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_EXC
    } state_e;

    localparam logic [1:0] MT_BYTE = 2'd0;
    localparam logic [1:0] MT_HALF = 2'd1;
    localparam logic [1:0] MT_WORD = 2'd2;
    localparam logic [1:0] MT_ILL  = 2'd3;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_ILLEGAL  = 2'b10,
        EXC_TIMEOUT  = 2'b11
    } exc_cause_e;

    function automatic logic [2:0] beat_count(input logic [1:0] mt);
        case (mt)
            MT_BYTE: beat_count = 3'd1;
            MT_HALF: beat_count = 3'd2;
            default: beat_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_seq_ctrl_load_extend.sv
// Collects load bytes into lanes and publishes the sign-extended result
// on the final beat; the result holds until the next load completes.
module load_extend
    import mem_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cap_en,
    input  logic        last,
    input  logic [1:0]  idx,
    input  logic [7:0]  byte_in,
    input  logic [1:0]  mtype,
    output logic [31:0] rdata
);

    logic [31:0] lanes;
    logic [31:0] merged;
    logic [31:0] extended;

    always_comb begin
        merged = lanes;
        merged[{idx, 3'b000} +: 8] = byte_in;
    end

    always_comb begin
        case (mtype)
            MT_BYTE: extended = {{24{merged[7]}}, merged[7:0]};
            MT_HALF: extended = {{16{merged[15]}}, merged[15:0]};
            default: extended = merged;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes <= '0;
            rdata <= '0;
        end else if (cap_en) begin
            lanes <= merged;
            if (last) rdata <= extended;
        end
    end

endmodule

// File: rtl/mem_seq_ctrl.sv
// MEM-stage controller: splits loads/stores into byte beats on a
// byte-wide memory, with alignment, illegal-op and timeout exceptions.
module mem_seq_ctrl
    import mem_seq_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              MemReadEn,
    input  logic              MemWriteEn,
    input  logic [1:0]        MemType,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              exc_valid,
    output logic [1:0]        exc_cause
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e            state;
    exc_cause_e        cause;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wbuf;
    logic [1:0]        mtype;
    logic              is_load;
    logic [1:0]        idx;
    logic [2:0]        nbeats;
    logic [TW-1:0]     tcnt;

    logic req_seen;
    logic illegal;
    logic misalign;
    logic in_acc;
    logic last;
    logic abort;
    logic cap_en;

    assign req_seen = (state == S_IDLE) && req_valid && !flush
                    && (MemReadEn || MemWriteEn);
    assign illegal  = (MemReadEn && MemWriteEn) || (MemType == MT_ILL);
    assign misalign = ((MemType == MT_HALF) && addr[0])
                    || ((MemType == MT_WORD) && (addr[1:0] != 2'b00));

    assign in_acc = (state == S_ACCESS);
    assign last   = ({1'b0, idx} == (nbeats - 3'd1));
    // Flush only cancels loads; stores must finish every beat.
    assign abort  = in_acc && flush && is_load;
    assign cap_en = in_acc && mem_ready && is_load && !abort;

    assign mem_addr    = base + ADDR_W'(idx);
    assign mem_re      = in_acc && is_load;
    assign mem_we      = in_acc && !is_load;
    assign mem_wdata   = wbuf[{idx, 3'b000} +: 8];
    assign stall       = req_seen || in_acc;
    assign rdata_valid = (state == S_DONE);
    assign exc_valid   = (state == S_EXC);
    assign exc_cause   = cause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cause   <= EXC_NONE;
            base    <= '0;
            wbuf    <= '0;
            mtype   <= MT_BYTE;
            is_load <= 1'b0;
            idx     <= '0;
            nbeats  <= 3'd1;
            tcnt    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_seen) begin
                        if (illegal) begin
                            state <= S_EXC;
                            cause <= EXC_ILLEGAL;
                        end else if (misalign) begin
                            state <= S_EXC;
                            cause <= EXC_MISALIGN;
                        end else begin
                            state   <= S_ACCESS;
                            base    <= addr;
                            wbuf    <= wdata;
                            mtype   <= MemType;
                            is_load <= MemReadEn;
                            nbeats  <= beat_count(MemType);
                            idx     <= '0;
                            tcnt    <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (abort) begin
                        state <= S_IDLE;
                        idx   <= '0;
                        tcnt  <= '0;
                    end else if (mem_ready) begin
                        tcnt <= '0;
                        if (last) state <= S_DONE;
                        else      idx   <= idx + 2'd1;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        state <= S_EXC;
                        cause <= EXC_TIMEOUT;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    idx   <= '0;
                end
                S_EXC: begin
                    state <= S_IDLE;
                    cause <= EXC_NONE;
                    idx   <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    load_extend u_load_extend (
        .clk     (clk),
        .rst_n   (rst_n),
        .cap_en  (cap_en),
        .last    (last),
        .idx     (idx),
        .byte_in (mem_rdata),
        .mtype   (mtype),
        .rdata   (rdata)
    );

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Scoreboard bench for mem_seq_ctrl: byte memory responder, expected
// beat and response queues, directed scenarios plus random traffic.
module tb_mem_seq_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        MemReadEn = 1'b0;
    logic        MemWriteEn = 1'b0;
    logic [1:0]  MemType = 2'd0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        flush = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        exc_valid;
    logic [1:0]  exc_cause;

    mem_seq_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .MemReadEn(MemReadEn), .MemWriteEn(MemWriteEn),
        .MemType(MemType), .addr(addr), .wdata(wdata), .flush(flush),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .exc_valid(exc_valid),
        .exc_cause(exc_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_exc;
        logic [31:0] data;
        logic [1:0]  cause;
    } resp_t;

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [7:0]  d;
    } beat_t;

    resp_t       resp_q[$];
    beat_t       beat_q[$];
    logic [7:0]  mem [0:1023];
    logic [31:0] last_load = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          resp_cnt = 0;
    int          beats_done = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          hang = 0;
    int          wait_cnt = -1;

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Memory responder and output monitor share one negedge process.
    always @(negedge clk) begin
        beat_t b;
        resp_t r;
        mem_ready = 1'b0;
        if (mem_re || mem_we) begin
            n_checks++;
            if (beat_q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_strobe got=re%0b/we%0b exp=none",
                         mem_re, mem_we);
            end
            if (wait_cnt < 0) wait_cnt = $urandom_range(lat_max, lat_min);
            if (wait_cnt == 0 && !hang) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[9:0]];
                wait_cnt = -1;
                beats_done++;
                if (beat_q.size() != 0) begin
                    b = beat_q.pop_front();
                    check("beat_we", {31'd0, mem_we}, {31'd0, b.we});
                    check("beat_addr", mem_addr, b.a);
                    if (b.we) check("beat_wdata", {24'd0, mem_wdata},
                                    {24'd0, b.d});
                end
            end else if (wait_cnt > 0) begin
                wait_cnt--;
            end
        end else begin
            wait_cnt = -1;
        end
        if (rdata_valid || exc_valid) begin
            resp_cnt++;
            n_checks++;
            if (resp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_resp got=rv%0b/ev%0b exp=none",
                         rdata_valid, exc_valid);
            end else begin
                r = resp_q.pop_front();
                check("resp_kind", {31'd0, exc_valid}, {31'd0, r.is_exc});
                if (r.is_exc) check("exc_cause", {30'd0, exc_cause},
                                    {30'd0, r.cause});
                else check("rdata", rdata, r.data);
            end
        end
    end

    function automatic logic [31:0] load_val(logic [1:0] mt,
                                             logic [31:0] a);
        logic [31:0] w;
        w = {mem[a[9:0] + 10'd3], mem[a[9:0] + 10'd2],
             mem[a[9:0] + 10'd1], mem[a[9:0]]};
        case (mt)
            2'd0:    return 32'($signed(w[7:0]));
            2'd1:    return 32'($signed(w[15:0]));
            default: return w;
        endcase
    endfunction

    function automatic int nbytes(logic [1:0] mt);
        return (mt == 2'd0) ? 1 : (mt == 2'd1) ? 2 : 4;
    endfunction

    // Reference model: returns 1 if a completion/exception is expected.
    function automatic bit model_push(bit re, bit we, logic [1:0] mt,
                                      logic [31:0] a, logic [31:0] wd,
                                      bit fl);
        resp_t r;
        beat_t b;
        if (!(re || we) || fl) return 0;
        r.is_exc = 1;
        r.data = '0;
        if ((re && we) || mt == 2'd3) begin
            r.cause = 2'b10;
        end else if ((mt == 2'd1 && a[0]) || (mt == 2'd2 && a[1:0] != 0)) begin
            r.cause = 2'b01;
        end else begin
            r.is_exc = 0;
            r.cause = 2'b00;
            for (int i = 0; i < nbytes(mt); i++) begin
                b.we = we;
                b.a = a + i;
                b.d = wd[8*i +: 8];
                beat_q.push_back(b);
            end
            if (re) begin
                last_load = load_val(mt, a);
            end else begin
                for (int i = 0; i < nbytes(mt); i++)
                    mem[(a[9:0] + 10'(i))] = wd[8*i +: 8];
            end
            r.data = last_load;
        end
        resp_q.push_back(r);
        return 1;
    endfunction

    task automatic issue(bit re, bit we, logic [1:0] mt, logic [31:0] a,
                         logic [31:0] wd, bit fl);
        @(negedge clk);
        req_valid = 1'b1;
        MemReadEn = re;
        MemWriteEn = we;
        MemType = mt;
        addr = a;
        wdata = wd;
        flush = fl;
        #1;
        check("stall_req", {31'd0, stall}, {31'd0, (re || we) && !fl});
        @(negedge clk);
        req_valid = 1'b0;
        MemReadEn = 1'b0;
        MemWriteEn = 1'b0;
        flush = 1'b0;
    endtask

    task automatic wait_resp(int bound);
        int start;
        bit got;
        start = resp_cnt;
        got = 0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            if (resp_cnt > start) begin
                got = 1;
                break;
            end
        end
        check("resp_arrived", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_beats(int target);
        bit got;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (beats_done >= target) begin
                got = 1;
                break;
            end
        end
        check("beats_reached", {31'd0, got}, 32'd1);
    endtask

    task automatic do_req(bit re, bit we, logic [1:0] mt, logic [31:0] a,
                          logic [31:0] wd, bit fl);
        bit exp;
        exp = model_push(re, we, mt, a, wd, fl);
        issue(re, we, mt, a, wd, fl);
        if (exp) wait_resp(200);
        else repeat (3) @(negedge clk);
    endtask

    initial begin
        int cnt;
        int b0;
        beat_t bb;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        check("rst_pulses", {30'd0, rdata_valid, exc_valid}, 32'd0);
        check("rst_cause", {30'd0, exc_cause}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LW 0x100, one wait cycle per byte
        lat_min = 1;
        lat_max = 1;
        mem[10'h100] = 8'h78;
        mem[10'h101] = 8'h56;
        mem[10'h102] = 8'h34;
        mem[10'h103] = 8'h12;
        do_req(1, 0, 2'd2, 32'h100, 32'h0, 0);
        check("lw_value", last_load, 32'h12345678);

        // LH negative, LB positive
        mem[10'h202] = 8'h34;
        mem[10'h203] = 8'h80;
        do_req(1, 0, 2'd1, 32'h202, 32'h0, 0);
        check("lh_value", last_load, 32'hFFFF8034);
        mem[10'h050] = 8'h7F;
        do_req(1, 0, 2'd0, 32'h050, 32'h0, 0);
        check("lb_value", last_load, 32'h0000007F);

        // Misaligned SW: stall only in the request cycle
        void'(model_push(0, 1, 2'd2, 32'h101, 32'h11223344, 0));
        issue(0, 1, 2'd2, 32'h101, 32'h11223344, 0);
        check("misalign_stall_after", {31'd0, stall}, 32'd0);
        wait_resp(10);

        // SB with no ready: timeout after TO strobe cycles
        hang = 1;
        bb.we = 1;
        bb.a = 32'h10;
        bb.d = 8'hDD;
        beat_q.push_back(bb);
        resp_q.push_back('{1, 32'h0, 2'b11});
        issue(0, 1, 2'd0, 32'h10, 32'hAABBCCDD, 0);
        check("sb_wdata", {24'd0, mem_wdata}, 32'hDD);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (exc_valid) break;
            if (mem_we) cnt++;
            @(negedge clk);
        end
        check("timeout_we_cycles", cnt, TO);
        @(negedge clk);
        hang = 0;
        beat_q.delete();

        // LW flushed after first beat
        lat_min = 2;
        lat_max = 2;
        b0 = beats_done;
        for (int i = 0; i < 2; i++) begin
            bb.we = 0;
            bb.a = 32'h120 + i;
            bb.d = 0;
            beat_q.push_back(bb);
        end
        issue(1, 0, 2'd2, 32'h120, 32'h0, 0);
        wait_beats(b0 + 1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ld_re_off", {31'd0, mem_re}, 32'd0);
        repeat (6) @(negedge clk);
        check("flush_ld_rdata_held", rdata, last_load);
        beat_q.delete();

        // SW flushed after first beat still writes all four bytes
        b0 = beats_done;
        void'(model_push(0, 1, 2'd2, 32'h140, 32'hCAFEF00D, 0));
        issue(0, 1, 2'd2, 32'h140, 32'hCAFEF00D, 0);
        wait_beats(b0 + 1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_resp(100);
        check("flush_st_beats", beats_done - b0, 4);

        // Reset during the third beat of a load
        lat_min = 3;
        lat_max = 3;
        b0 = beats_done;
        for (int i = 0; i < 3; i++) begin
            bb.we = 0;
            bb.a = 32'h180 + i;
            bb.d = 0;
            beat_q.push_back(bb);
        end
        issue(1, 0, 2'd2, 32'h180, 32'h0, 0);
        wait_beats(b0 + 2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_re", {31'd0, mem_re}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        beat_q.delete();
        last_load = '0;
        @(negedge clk);
        check("post_rst_idle", {30'd0, stall, mem_re}, 32'd0);

        // Random traffic
        lat_min = 0;
        lat_max = 3;
        for (int n = 0; n < 80; n++) begin
            int k;
            bit re, we, fl;
            logic [1:0] mt;
            logic [31:0] a;
            k = $urandom_range(19, 0);
            re = $urandom_range(1, 0);
            we = !re;
            if (k == 0) begin re = 0; we = 0; end
            if (k == 1) begin re = 1; we = 1; end
            fl = (k == 2);
            mt = 2'($urandom_range(3, 0));
            a = $urandom_range(1019, 0);
            if ($urandom_range(3, 0) != 0 && mt == 2'd2) a[1:0] = 2'b00;
            if ($urandom_range(3, 0) != 0 && mt == 2'd1) a[0] = 1'b0;
            do_req(re, we, mt, a, $urandom, fl);
        end
        repeat (4) @(negedge clk);
        check("resp_q_drained", resp_q.size(), 0);
        check("beat_q_drained", beat_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
